// File: rtl/pio_in_pkg.sv
// Shared constants and the edge-select helper for the input PIO.
// Latency: none. This package only holds constants and a pure function.
// Backpressure: not applicable.
package pio_in_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int DB_CNT_W = 16;

    // Reports whether the cur/prev pair forms an edge of the selected kind.
    function automatic logic edge_hit(input int etype, input logic cur, input logic prev);
        case (etype)
            EDGE_FALL: return ~cur & prev;
            EDGE_ANY:  return cur ^ prev;
            default:   return cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_in_capture_if.sv
// Avalon-MM slave bus of the input PIO, together with its interrupt line.
// Latency: readdata is registered and follows address by one cycle.
// Backpressure: none. There are no wait states, so one access is taken per cycle.
interface pio_in_capture_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, output write, output writedata,
                    input  readdata, input  irq);
    modport slave  (input  address, input  write, input  writedata,
                    output readdata, output irq);
endinterface

// File: rtl/pio_in_bit.sv
// Per-bit path: synchroniser, optional debouncer, filtered register and edge detect.
// Latency: SYNC_STAGES+1 cycles to filt; more when debouncing; edge_pulse is valid while filt differs from filt_d.
// Backpressure: none. The input is sampled every cycle.
module pio_in_bit
    import pio_in_pkg::*;
#(
    parameter int EDGE_TYPE       = EDGE_RISE,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic filt,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   filt_d;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // With no debounce, register the last synchroniser stage once.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) filt <= 1'b0;
                else       filt <= synced;
            end
        end else begin : g_debounce
            localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [DB_CNT_W-1:0] cnt_q;

            // Accept a new level only after it has been seen on DEBOUNCE_CYCLES consecutive samples.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                    filt  <= 1'b0;
                end else if (synced == filt) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    filt  <= synced;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    // Delay filt by one cycle so the edge detector has a reference value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) filt_d <= 1'b0;
        else       filt_d <= filt;
    end

    assign edge_pulse = edge_hit(EDGE_TYPE, filt, filt_d);

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO with filtered data, a W1C edge-capture register and a maskable level irq.
// Latency: readdata is registered one cycle after address; writes land on the clock edge of the strobe.
// Backpressure: none. There are no wait states, and a capture set wins over a W1C clear in the same cycle.
module pio_in_capture
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int EDGE_TYPE       = EDGE_RISE,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    pio_in_capture_if.slave  bus,
    input  logic [WIDTH-1:0] in_port
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_cap_q;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // writedata bits above WIDTH are ignored by design.
    assign unused_wdata = ^bus.writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_bit #(
            .EDGE_TYPE       (EDGE_TYPE),
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .in_bit     (in_port[i]),
            .filt       (filt[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

    // Load the interrupt mask on a write to its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       irq_mask_q <= '0;
        else if (bus.write && bus.address == ADDR_MASK)  irq_mask_q <= bus.writedata[WIDTH-1:0];
    end

    // Select the bits that a write-1-to-clear access on EDGE_CAP will clear.
    always_comb begin
        w1c = '0;
        if (bus.write && bus.address == ADDR_EDGE) w1c = bus.writedata[WIDTH-1:0];
    end

    // Update edge capture; the OR comes last so a new edge survives a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) edge_cap_q <= '0;
        else       edge_cap_q <= (edge_cap_q & ~w1c) | edge_pulse;
    end

    // Read mux; unimplemented and reserved bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = filt;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap_q;
            default:   rd_mux = '0;
        endcase
    end

    // Register read data every cycle, whether or not a read strobe is present.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_mux;
    end

    assign bus.irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_in_capture.sv
// Bench for pio_in_capture: two configurations, directed vectors, queue-based scoreboard.
// Latency: each access is compared at the falling edge that follows its rising clock edge.
// Backpressure: none. Accesses are issued one per cycle.
module tb_pio_in_capture;
    import pio_in_pkg::*;

    logic       clk;
    logic       rst_a, rst_b;
    logic [7:0] in_a, in_b;

    pio_in_capture_if bus_a ();
    pio_in_capture_if bus_b ();

    // A: rising edge, no debounce. B: any edge, 4-cycle debounce.
    pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a), .in_port(in_a));
    pio_in_capture #(.WIDTH(8), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b), .in_port(in_b));

    int          vectors = 0;
    int          miscompares = 0;
    logic        pend = 1'b0;
    logic        mon_vld = 1'b0;
    int          q_dut[$];
    logic [31:0] q_rd[$];
    logic        q_irq[$];
    string       q_nm[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one bus access for one cycle and queue the expected readdata and irq.
    task automatic acc(input int d, input bit wr, input logic [1:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eirq, input string nm);
        if (d == 0) begin
            bus_a.address = a; bus_a.write = wr; bus_a.writedata = wd;
        end else begin
            bus_b.address = a; bus_b.write = wr; bus_b.writedata = wd;
        end
        q_dut.push_back(d);
        q_rd.push_back(erd);
        q_irq.push_back(eirq);
        q_nm.push_back(nm);
        pend = 1'b1;
        @(posedge clk);
        #1;
        pend = 1'b0;
        bus_a.write = 1'b0;
        bus_b.write = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) mon_vld <= pend;

    // Monitor: for each access, pop the expected values and compare them with the DUT.
    always @(negedge clk) begin
        if (mon_vld) begin
            vectors++;
            if (q_dut.size() == 0) begin
                miscompares++;
                $display("FAIL monitor: output presented with empty expect queue");
            end else begin
                int          d;
                logic [31:0] erd, ard;
                logic        eirq, airq;
                string       nm;
                d    = q_dut.pop_front();
                erd  = q_rd.pop_front();
                eirq = q_irq.pop_front();
                nm   = q_nm.pop_front();
                ard  = (d == 0) ? bus_a.readdata : bus_b.readdata;
                airq = (d == 0) ? bus_a.irq : bus_b.irq;
                if (ard !== erd || airq !== eirq) begin
                    miscompares++;
                    $display("FAIL %s: readdata=%h irq=%b, expected readdata=%h irq=%b",
                             nm, ard, airq, erd, eirq);
                end
            end
        end
    end

    initial begin
        bus_a.address = '0; bus_a.write = 1'b0; bus_a.writedata = '0;
        bus_b.address = '0; bus_b.write = 1'b0; bus_b.writedata = '0;
        in_a = '0; in_b = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        tick(3);
        rst_a = 1'b0; rst_b = 1'b0;

        // ---- DUT A: reset values ----
        acc(0, 0, ADDR_DATA, 0, 32'h0, 0, "a_rst_data");
        acc(0, 0, ADDR_RSVD, 0, 32'h0, 0, "a_rst_rsvd");
        acc(0, 0, ADDR_MASK, 0, 32'h0, 0, "a_rst_mask");
        acc(0, 0, ADDR_EDGE, 0, 32'h0, 0, "a_rst_edge");
        // Mask bits above WIDTH read back as zero; a write to the reserved address is ignored.
        acc(0, 1, ADDR_MASK, 32'hFFFF_FFFF, 32'h0, 0, "a_wmask_all");
        acc(0, 0, ADDR_MASK, 0, 32'h0000_00FF, 0, "a_mask_width");
        acc(0, 1, ADDR_RSVD, 32'hFFFF_FFFF, 32'h0, 0, "a_wr_rsvd");
        acc(0, 1, ADDR_MASK, 32'h0, 32'h0000_00FF, 0, "a_wmask_zero");
        acc(0, 0, ADDR_RSVD, 0, 32'h0, 0, "a_rsvd_zero");
        // Read latency of DATA: the value reaches filt after 3 edges and readdata after 4.
        in_a = 8'hA5;
        acc(0, 0, ADDR_DATA, 0, 32'h0, 0, "a_lat_e1");
        acc(0, 0, ADDR_DATA, 0, 32'h0, 0, "a_lat_e2");
        acc(0, 0, ADDR_DATA, 0, 32'h0, 0, "a_lat_e3");
        acc(0, 0, ADDR_DATA, 0, 32'h0000_00A5, 0, "a_data_a5");
        acc(0, 0, ADDR_EDGE, 0, 32'h0000_00A5, 0, "a_cap_masked");
        acc(0, 1, ADDR_EDGE, 32'hFFFF_FFFF, 32'h0000_00A5, 0, "a_w1c_all");
        acc(0, 0, ADDR_EDGE, 0, 32'h0, 0, "a_cap_clear");
        // Falling edges are ignored in rising mode.
        in_a = 8'h00;
        tick(6);
        acc(0, 0, ADDR_EDGE, 0, 32'h0, 0, "a_no_fall");
        acc(0, 0, ADDR_DATA, 0, 32'h0, 0, "a_data_zero");
        // Unmasked rising edge on bit 0 raises irq; W1C drops it at the writing edge.
        acc(0, 1, ADDR_MASK, 32'h1, 32'h0, 0, "a_wmask_1");
        in_a = 8'h01;
        tick(6);
        acc(0, 0, ADDR_EDGE, 0, 32'h1, 1, "a_rise_cap");
        acc(0, 1, ADDR_EDGE, 32'h1, 32'h1, 0, "a_w1c_irq");
        acc(0, 0, ADDR_EDGE, 0, 32'h0, 0, "a_cap_after_w1c");
        // Same-edge set and W1C clear: the set wins.
        in_a = 8'h00;
        tick(6);
        in_a = 8'h01;
        tick(3);
        acc(0, 1, ADDR_EDGE, 32'h1, 32'h0, 1, "a_set_prio");
        acc(0, 0, ADDR_EDGE, 0, 32'h1, 1, "a_prio_hold");

        // ---- DUT B: debounce and any-edge ----
        acc(1, 0, ADDR_DATA, 0, 32'h0, 0, "b_rst_data");
        acc(1, 0, ADDR_EDGE, 0, 32'h0, 0, "b_rst_edge");
        // A 3-cycle glitch on bit 2 never reaches filt.
        in_b = 8'h04;
        tick(3);
        in_b = 8'h00;
        for (int i = 0; i < 12; i++) acc(1, 0, ADDR_DATA, 0, 32'h0, 0, "b_glitch_data");
        acc(1, 0, ADDR_EDGE, 0, 32'h0, 0, "b_glitch_cap");
        // A 6-cycle pulse passes through and is captured.
        in_b = 8'h04;
        tick(6);
        in_b = 8'h00;
        tick(1);
        acc(1, 0, ADDR_DATA, 0, 32'h4, 0, "b_deb_data_1");
        acc(1, 0, ADDR_DATA, 0, 32'h4, 0, "b_deb_data_2");
        tick(15);
        acc(1, 0, ADDR_DATA, 0, 32'h0, 0, "b_deb_data_low");
        acc(1, 0, ADDR_EDGE, 0, 32'h4, 0, "b_deb_cap");
        acc(1, 1, ADDR_EDGE, 32'h4, 32'h4, 0, "b_deb_w1c");
        acc(1, 0, ADDR_EDGE, 0, 32'h0, 0, "b_deb_clear");
        // Toggles on bit 1 with the mask clear: edges are captured but irq stays low.
        in_b = 8'h02; tick(12);
        in_b = 8'h00; tick(12);
        in_b = 8'h02; tick(12);
        in_b = 8'h00; tick(12);
        acc(1, 0, ADDR_EDGE, 0, 32'h2, 0, "b_any_masked");
        acc(1, 1, ADDR_MASK, 32'h2, 32'h0, 1, "b_mask_on");
        acc(1, 0, ADDR_MASK, 0, 32'h2, 1, "b_mask_read");
        // Reset mid-debounce: the counter restarts from zero after release.
        in_b = 8'h01;
        tick(4);
        rst_b = 1'b1;
        tick(2);
        rst_b = 1'b0;
        acc(1, 0, ADDR_DATA, 0, 32'h0, 0, "b_rst2_data");
        acc(1, 0, ADDR_MASK, 0, 32'h0, 0, "b_rst2_mask");
        acc(1, 0, ADDR_EDGE, 0, 32'h0, 0, "b_rst2_edge");
        acc(1, 0, ADDR_RSVD, 0, 32'h0, 0, "b_rst2_rsvd");
        acc(1, 0, ADDR_DATA, 0, 32'h0, 0, "b_rst2_hold1");
        acc(1, 0, ADDR_DATA, 0, 32'h0, 0, "b_rst2_hold2");
        tick(4);
        acc(1, 0, ADDR_DATA, 0, 32'h1, 0, "b_rst2_settle");
        acc(1, 0, ADDR_EDGE, 0, 32'h1, 0, "b_rst2_cap");

        tick(3);
        if (q_dut.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, required 0", q_dut.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
